// File: rtl/add_sched_pkg.sv
// add_sched_pkg: shared widths, FSM encoding and result bundle for the
// round-robin adder scheduler and its add/sub datapath.
package add_sched_pkg;

    localparam int W    = 6;
    localparam int NREQ = 2;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef logic [W-1:0] word_t;

    typedef struct packed {
        word_t s;
        logic  cout;
        logic  ov;
        logic  neg;
        logic  zero;
    } add_result_t;

endpackage

// File: rtl/add_sched_circ_add.sv
// Circ_add: 6-bit add/sub unit. The caller pre-inverts B for subtraction and
// raises i_res, which also serves as the carry-in so A + ~B + 1 = A - B.
module Circ_add
    import add_sched_pkg::*;
(
    input  word_t i_a,
    input  word_t i_b,
    input  logic  i_res,
    input  logic  i_cin,
    output word_t o_s,
    output logic  o_cout,
    output logic  o_overflow,
    output logic  o_negativo,
    output logic  o_cero
);

    logic         w_carry_in;
    logic [W-2:0] w_low;
    logic         w_c_msb;
    logic         w_s_msb;
    logic         w_cout;

    // The low bits and the MSB are summed separately so the carry into the
    // MSB is visible for signed overflow detection.
    assign w_carry_in = i_res | i_cin;
    assign {w_c_msb, w_low} = {1'b0, i_a[W-2:0]} + {1'b0, i_b[W-2:0]}
                            + {{(W-1){1'b0}}, w_carry_in};
    assign {w_cout, w_s_msb} = {1'b0, i_a[W-1]} + {1'b0, i_b[W-1]} + {1'b0, w_c_msb};

    assign o_s        = {w_s_msb, w_low};
    assign o_cout     = w_cout;
    assign o_overflow = w_c_msb ^ w_cout;
    assign o_negativo = w_s_msb & i_res;
    assign o_cero     = ({w_s_msb, w_low} == '0);

endmodule

// File: rtl/add_sched.sv
// add_sched: round-robin scheduler sharing one Circ_add between two
// valid/ready requesters, returning tagged results on one response channel.
module add_sched
    import add_sched_pkg::*;
#(
    parameter int WIDTH   = W,
    parameter int NUM_REQ = NREQ
)
(
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NREQ-1:0]           i_req_valid,
    output logic [NREQ-1:0]           o_req_ready,
    input  logic [NREQ-1:0][W-1:0]    i_req_a,
    input  logic [NREQ-1:0][W-1:0]    i_req_b,
    input  logic [NREQ-1:0]           i_req_sub,
    output logic                      o_resp_valid,
    input  logic                      i_resp_ready,
    output logic                      o_resp_id,
    output logic [W-1:0]              o_resp_s,
    output logic                      o_resp_cout,
    output logic                      o_resp_ov,
    output logic                      o_resp_neg,
    output logic                      o_resp_zero
);

    // The datapath is hard-wired to Circ_add's width and a two-way arbiter.
    if (WIDTH != 6 || NUM_REQ != 2) begin : g_bad_config
        $error("add_sched supports only WIDTH=6 and NUM_REQ=2");
    end

    state_t      r_state;
    state_t      w_next_state;
    logic        r_rr_ptr;
    word_t       r_op_a;
    word_t       r_op_b;
    logic        r_op_sub;
    logic        r_op_id;
    add_result_t r_resp;
    logic        r_resp_id;

    logic        w_any_valid;
    logic        w_grant_id;
    logic        w_accept;
    logic        w_capture;
    logic        w_resp_done;
    word_t       w_add_b;
    word_t       w_sum;
    logic        w_cout;
    logic        w_ov;
    logic        w_neg;
    logic        w_zero;

    // Arbitration: a lone requester wins; a tie goes to the pointer.
    always_comb begin
        w_any_valid = |i_req_valid;
        if (i_req_valid == 2'b11) begin
            w_grant_id = r_rr_ptr;
        end else begin
            w_grant_id = i_req_valid[1];
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: one cycle of execution, then hold until consumed.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_any_valid) w_next_state = EXEC;
            EXEC:    w_next_state = RESP;
            RESP:    if (i_resp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // FSM outputs; ready is held low during reset so no request is lost.
    always_comb begin
        o_req_ready  = '0;
        o_resp_valid = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_resp_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_any_valid && !i_rst) begin
                    o_req_ready[w_grant_id] = 1'b1;
                    w_accept                = 1'b1;
                end
            end
            EXEC: w_capture = 1'b1;
            RESP: begin
                o_resp_valid = 1'b1;
                w_resp_done  = i_resp_ready;
            end
            default: ;
        endcase
    end

    // Operand registers: requester inputs are sampled only on the handshake.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_op_sub <= 1'b0;
            r_op_id  <= 1'b0;
        end else if (w_accept) begin
            r_op_a   <= i_req_a[w_grant_id];
            r_op_b   <= i_req_b[w_grant_id];
            r_op_sub <= i_req_sub[w_grant_id];
            r_op_id  <= w_grant_id;
        end
    end

    // Response registers: captured at the end of EXEC and held through RESP.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_resp    <= '0;
            r_resp_id <= 1'b0;
        end else if (w_capture) begin
            r_resp    <= '{s: w_sum, cout: w_cout, ov: w_ov, neg: w_neg, zero: w_zero};
            r_resp_id <= r_op_id;
        end
    end

    // Round-robin pointer: after serving one requester, favour the other.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rr_ptr <= 1'b0;
        end else if (w_resp_done) begin
            r_rr_ptr <= ~r_resp_id;
        end
    end

    assign w_add_b = r_op_sub ? ~r_op_b : r_op_b;

    Circ_add u_circ_add (
        .i_a        (r_op_a),
        .i_b        (w_add_b),
        .i_res      (r_op_sub),
        .i_cin      (1'b0),
        .o_s        (w_sum),
        .o_cout     (w_cout),
        .o_overflow (w_ov),
        .o_negativo (w_neg),
        .o_cero     (w_zero)
    );

    assign o_resp_id   = r_resp_id;
    assign o_resp_s    = r_resp.s;
    assign o_resp_cout = r_resp.cout;
    assign o_resp_ov   = r_resp.ov;
    assign o_resp_neg  = r_resp.neg;
    assign o_resp_zero = r_resp.zero;

endmodule
